// File: rtl/max_pooling.sv
// Streaming 2x2 max-pooling over a (2*SIZE)x(2*SIZE) signed 16-bit raster map.
// Each pooled maximum is paired with the argmax history code used by the unpooler.
module max_pooling #(
   parameter int SIZE = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               pool_start,
   input  logic               in_valid,
   input  logic signed [15:0] in_value,
   output logic               out_valid,
   output logic signed [15:0] pooled_value,
   output logic [2:0]         history_value,
   output logic               pool_end
);
   localparam int CW = $clog2(2 * SIZE);
   localparam int BW = (CW > 1) ? CW - 1 : 1;
   localparam logic [CW-1:0] LAST = CW'(2 * SIZE - 1);

   logic [CW-1:0]      row_q, row_d;
   logic [CW-1:0]      col_q, col_d;
   logic               out_valid_q, out_valid_d;
   logic signed [15:0] pooled_q, pooled_d;
   logic [2:0]         hist_q, hist_d;
   logic               pool_end_q, pool_end_d;

   logic signed [15:0] pair_q;
   logic signed [15:0] lb_val_q [SIZE];
   logic               lb_idx_q [SIZE];

   logic               accept_s;
   logic               gt_s;
   logic               last_s;
   logic [BW-1:0]      slot_s;
   logic signed [15:0] h_s;
   logic signed [15:0] top_val_s;
   logic               top_idx_s;

   // Next-state logic: raster counters, window resolution and frame-complete flag.
   always_comb begin
      accept_s    = pool_start && in_valid && !pool_end_q;
      slot_s      = BW'(col_q >> 1);
      gt_s        = in_value > pair_q;
      h_s         = gt_s ? in_value : pair_q;
      top_val_s   = lb_val_q[slot_s];
      top_idx_s   = lb_idx_q[slot_s];
      last_s      = (row_q == LAST) && (col_q == LAST);
      row_d       = row_q;
      col_d       = col_q;
      out_valid_d = 1'b0;
      pooled_d    = pooled_q;
      hist_d      = hist_q;
      pool_end_d  = pool_end_q;
      if (!pool_start) begin
         row_d      = '0;
         col_d      = '0;
         pool_end_d = 1'b0;
      end else if (accept_s) begin
         if (last_s) begin
            row_d = '0;
            col_d = '0;
         end else if (col_q == LAST) begin
            row_d = row_q + CW'(1);
            col_d = '0;
         end else begin
            col_d = col_q + CW'(1);
         end
         // Bottom-right sample closes the window; strict compare keeps the earlier position on ties.
         if (col_q[0] && row_q[0]) begin
            out_valid_d = 1'b1;
            if (h_s > top_val_s) begin
               pooled_d = h_s;
               hist_d   = {1'b0, 1'b1, gt_s};
            end else begin
               pooled_d = top_val_s;
               hist_d   = {2'b00, top_idx_s};
            end
         end else begin
            out_valid_d = 1'b0;
         end
         if (last_s) begin
            pool_end_d = 1'b1;
         end else begin
            pool_end_d = pool_end_q;
         end
      end else begin
         out_valid_d = 1'b0;
      end
   end

   // Control state and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row_q       <= '0;
         col_q       <= '0;
         out_valid_q <= 1'b0;
         pooled_q    <= 16'sd0;
         hist_q      <= 3'd0;
         pool_end_q  <= 1'b0;
      end else begin
         row_q       <= row_d;
         col_q       <= col_d;
         out_valid_q <= out_valid_d;
         pooled_q    <= pooled_d;
         hist_q      <= hist_d;
         pool_end_q  <= pool_end_d;
      end
   end

   // Datapath storage: even-column sample and the top-row horizontal maxima.
   always_ff @(posedge clk) begin
      if (accept_s && !col_q[0]) begin
         pair_q <= in_value;
      end
      if (accept_s && col_q[0] && !row_q[0]) begin
         lb_val_q[slot_s] <= h_s;
         lb_idx_q[slot_s] <= gt_s;
      end
   end

   assign out_valid     = out_valid_q;
   assign pooled_value  = pooled_q;
   assign history_value = hist_q;
   assign pool_end      = pool_end_q;
endmodule

// File: tb/tb_max_pooling.sv
// Self-checking bench for max_pooling: a SIZE=2 and a SIZE=8 instance driven
// with directed and random frames, checked against a window-max reference model.
module tb_max_pooling;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset_n;
   logic               ps2, iv2, ov2, pe2;
   logic signed [15:0] in2, pv2;
   logic [2:0]         hv2;
   logic               ps8, iv8, ov8, pe8;
   logic signed [15:0] in8, pv8;
   logic [2:0]         hv8;

   max_pooling #(.SIZE(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .pool_start(ps2), .in_valid(iv2), .in_value(in2),
      .out_valid(ov2), .pooled_value(pv2), .history_value(hv2), .pool_end(pe2));

   max_pooling #(.SIZE(8)) dut8 (
      .clk(clk), .reset_n(reset_n), .pool_start(ps8), .in_valid(iv8), .in_value(in8),
      .out_valid(ov8), .pooled_value(pv8), .history_value(hv8), .pool_end(pe8));

   int checks = 0;
   int errors = 0;
   int pix [256];
   int exp_val[$], exp_hist[$];
   int qv2[$], qh2[$], qe2[$];
   int qv8[$], qh8[$], qe8[$];

   // Capture every output pulse half a cycle away from the active edge.
   always @(negedge clk) begin
      if (ov2) begin
         qv2.push_back(int'(pv2)); qh2.push_back(int'(hv2)); qe2.push_back(int'(pe2));
      end
      if (ov8) begin
         qv8.push_back(int'(pv8)); qh8.push_back(int'(hv8)); qe8.push_back(int'(pe8));
      end
   end

   task automatic chk(input string tag, input int obs, input int req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int rnd16();
      logic [15:0] r;
      r = 16'($urandom);
      return int'($signed(r));
   endfunction

   // Reference: first maximum in raster order of each 2x2 window.
   task automatic build_expected(input int sz);
      exp_val.delete();
      exp_hist.delete();
      for (int wr = 0; wr < sz; wr++) begin
         for (int wc = 0; wc < sz; wc++) begin
            int best, bi, v;
            best = pix[(2 * wr) * 2 * sz + 2 * wc];
            bi = 0;
            for (int k = 1; k < 4; k++) begin
               v = pix[(2 * wr + k / 2) * 2 * sz + 2 * wc + k % 2];
               if (v > best) begin
                  best = v;
                  bi = k;
               end
            end
            exp_val.push_back(best);
            exp_hist.push_back(bi);
         end
      end
   endtask

   task automatic set_win(input int sz, input int wr, input int wc,
                          input int a, input int b, input int c, input int d);
      pix[(2 * wr) * 2 * sz + 2 * wc]         = a;
      pix[(2 * wr) * 2 * sz + 2 * wc + 1]     = b;
      pix[(2 * wr + 1) * 2 * sz + 2 * wc]     = c;
      pix[(2 * wr + 1) * 2 * sz + 2 * wc + 1] = d;
   endtask

   task automatic clear_q(input int sel);
      if (sel == 2) begin
         qv2.delete(); qh2.delete(); qe2.delete();
      end else begin
         qv8.delete(); qh8.delete(); qe8.delete();
      end
   endtask

   task automatic feed(input int sel, input int v, input int gap);
      if (sel == 2) begin
         iv2 = 1'b1; in2 = 16'(v);
      end else begin
         iv8 = 1'b1; in8 = 16'(v);
      end
      step();
      iv2 = 1'b0;
      iv8 = 1'b0;
      repeat (gap) step();
   endtask

   task automatic compare(input int sel, input string tag);
      int ov[$], oh[$], oe[$];
      int n;
      if (sel == 2) begin
         ov = qv2; oh = qh2; oe = qe2;
      end else begin
         ov = qv8; oh = qh8; oe = qe8;
      end
      chk({tag, "_count"}, ov.size(), exp_val.size());
      n = (ov.size() < exp_val.size()) ? ov.size() : exp_val.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_val%0d", tag, i), ov[i], exp_val[i]);
         chk($sformatf("%s_hist%0d", tag, i), oh[i], exp_hist[i]);
         chk($sformatf("%s_end%0d", tag, i), oe[i], (i == exp_val.size() - 1) ? 1 : 0);
      end
   endtask

   // pool_start and the first sample rise together, so pixel (0,0) lands in the first cycle.
   task automatic run_frame(input int sel, input int maxgap, input string tag);
      build_expected(sel);
      clear_q(sel);
      if (sel == 2) ps2 = 1'b1; else ps8 = 1'b1;
      for (int i = 0; i < 4 * sel * sel; i++) begin
         feed(sel, pix[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
      end
      repeat (3) step();
      compare(sel, tag);
   endtask

   task automatic stop_frame(input int sel, input string tag);
      chk({tag, "_end_held"}, (sel == 2) ? int'(pe2) : int'(pe8), 1);
      if (sel == 2) ps2 = 1'b0; else ps8 = 1'b0;
      step();
      chk({tag, "_end_clr"}, (sel == 2) ? int'(pe2) : int'(pe8), 0);
      step();
   endtask

   task automatic chk_zero8(input string tag);
      chk({tag, "_ov"}, int'(ov8), 0);
      chk({tag, "_pv"}, int'(pv8), 0);
      chk({tag, "_hv"}, int'(hv8), 0);
      chk({tag, "_pe"}, int'(pe8), 0);
   endtask

   initial begin
      reset_n = 1'b0;
      ps2 = 1'b0; iv2 = 1'b0; in2 = 16'sd0;
      ps8 = 1'b0; iv8 = 1'b0; in8 = 16'sd0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero8("rst8");
      chk("rst2_ov", int'(ov2), 0);
      chk("rst2_pv", int'(pv2), 0);
      chk("rst2_pe", int'(pe2), 0);
      reset_n = 1'b1;
      step();

      for (int i = 0; i < 16; i++) pix[i] = i;
      run_frame(2, 0, "asc");
      chk("asc_first_val", qv2[0], 5);
      chk("asc_first_hist", qh2[0], 3);
      chk("asc_last_val", qv2[3], 15);
      stop_frame(2, "asc");

      for (int i = 0; i < 16; i++) pix[i] = 15 - i;
      run_frame(2, 0, "desc");
      chk("desc_first_val", qv2[0], 15);
      chk("desc_first_hist", qh2[0], 0);
      stop_frame(2, "desc");

      for (int i = 0; i < 16; i++) pix[i] = 32'h1234;
      run_frame(2, 1, "tie");
      stop_frame(2, "tie");

      set_win(2, 0, 0, -5, -3, -9, -4);
      set_win(2, 0, 1, -8, -7, 100, 2);
      set_win(2, 1, 0, -32768, 32767, 0, 0);
      set_win(2, 1, 1, -1, -1, -1, -1);
      run_frame(2, 0, "sgn");
      chk("sgn_w0_val", qv2[0], -3);
      chk("sgn_w0_hist", qh2[0], 1);
      chk("sgn_w1_val", qv2[1], 100);
      chk("sgn_w1_hist", qh2[1], 2);
      chk("sgn_w2_val", qv2[2], 32767);
      chk("sgn_w2_hist", qh2[2], 1);
      stop_frame(2, "sgn");

      for (int i = 0; i < 256; i++) pix[i] = rnd16();
      run_frame(8, 3, "rnd8");
      clear_q(8);
      for (int i = 0; i < 10; i++) feed(8, rnd16(), 0);
      repeat (3) step();
      chk("extra_pulses", qv8.size(), 0);
      stop_frame(8, "rnd8");

      ps8 = 1'b1;
      for (int i = 0; i < 37; i++) feed(8, rnd16(), 0);
      ps8 = 1'b0;
      step();
      step();
      for (int i = 0; i < 256; i++) pix[i] = rnd16();
      run_frame(8, 1, "restart");
      stop_frame(8, "restart");

      ps8 = 1'b1;
      for (int i = 0; i < 37; i++) feed(8, rnd16(), 0);
      reset_n = 1'b0;
      #1;
      chk_zero8("midrst_async");
      ps8 = 1'b0;
      step();
      chk_zero8("midrst_held");
      reset_n = 1'b1;
      step();
      for (int i = 0; i < 256; i++) pix[i] = rnd16();
      run_frame(8, 2, "postrst");
      stop_frame(8, "postrst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
